// File: rtl/gnn_aggregator.sv
// Neighbour feature aggregator: sums the 4-lane feature beats of one graph node
// with per-lane saturation and emits a one-cycle result pulse for the dnn stage.
module gnn_aggregator #(
  parameter int DATA_W  = 21,
  parameter int MAX_DEG = 16,
  parameter int CNT_W   = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     feat_valid,
  input  logic                     feat_last,
  input  logic signed [DATA_W-1:0] f0,
  input  logic signed [DATA_W-1:0] f1,
  input  logic signed [DATA_W-1:0] f2,
  input  logic signed [DATA_W-1:0] f3,
  output logic                     feat_ready,
  output logic signed [DATA_W-1:0] x0,
  output logic signed [DATA_W-1:0] x1,
  output logic signed [DATA_W-1:0] x2,
  output logic signed [DATA_W-1:0] x3,
  output logic                     out_ready,
  output logic [CNT_W-1:0]         deg,
  output logic                     sat,
  output logic                     deg_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]         ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]         CAP   = CNT_W'(MAX_DEG);

  // Returns {clamped, value}: widen by one bit, then clamp on sign disagreement.
  function automatic logic [DATA_W:0] sat_add(input logic signed [DATA_W-1:0] a,
                                              input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (s[DATA_W] != s[DATA_W-1]) begin
      if (s[DATA_W]) sat_add = {1'b1, MIN_V};
      else           sat_add = {1'b1, MAX_V};
    end else begin
      sat_add = {1'b0, s[DATA_W-1:0]};
    end
  endfunction

  state_t                    state, next_state;
  logic signed [DATA_W-1:0]  acc [4];
  logic signed [DATA_W-1:0]  next_acc [4];
  logic signed [DATA_W-1:0]  f_in [4];
  logic signed [DATA_W-1:0]  sum_val [4];
  logic [3:0]                sum_clamp;
  logic [CNT_W-1:0]          cnt, next_cnt, cnt_inc;
  logic                      node_sat, next_node_sat;
  logic                      trunc, next_trunc;
  logic                      do_emit, accept;

  assign f_in[0]    = f0;
  assign f_in[1]    = f1;
  assign f_in[2]    = f2;
  assign f_in[3]    = f3;
  assign feat_ready = rst_n & (state != EMIT);
  assign accept     = feat_valid & feat_ready;
  assign cnt_inc    = cnt + ONE;

  // Saturating lane sums of the running accumulator and the incoming beat.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      {sum_clamp[i], sum_val[i]} = sat_add(acc[i], f_in[i]);
    end
  end

  // Next-state, accumulator and emit decision.
  always_comb begin
    next_state    = state;
    next_cnt      = cnt;
    next_node_sat = node_sat;
    next_trunc    = trunc;
    do_emit       = 1'b0;
    for (int i = 0; i < 4; i++) next_acc[i] = acc[i];
    case (state)
      IDLE: begin
        if (accept) begin
          for (int i = 0; i < 4; i++) next_acc[i] = f_in[i];
          next_cnt      = ONE;
          next_node_sat = 1'b0;
          do_emit       = feat_last;
          next_state    = feat_last ? EMIT : ACC;
        end else begin
          next_state = IDLE;
        end
      end
      ACC: begin
        if (accept) begin
          for (int i = 0; i < 4; i++) next_acc[i] = sum_val[i];
          next_cnt      = cnt_inc;
          next_node_sat = node_sat | (|sum_clamp);
          if (feat_last) begin
            do_emit    = 1'b1;
            next_state = EMIT;
          end else if (cnt_inc == CAP) begin
            // Degree cap hit without an end marker: emit now, drop the rest.
            next_trunc = 1'b1;
            do_emit    = 1'b1;
            next_state = EMIT;
          end else begin
            next_state = ACC;
          end
        end else begin
          next_state = ACC;
        end
      end
      EMIT: begin
        next_trunc = 1'b0;
        next_state = trunc ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (accept && feat_last) next_state = IDLE;
        else                     next_state = DRAIN;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, accumulator and registered output update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < 4; i++) acc[i] <= {DATA_W{1'b0}};
      cnt       <= {CNT_W{1'b0}};
      node_sat  <= 1'b0;
      trunc     <= 1'b0;
      x0        <= {DATA_W{1'b0}};
      x1        <= {DATA_W{1'b0}};
      x2        <= {DATA_W{1'b0}};
      x3        <= {DATA_W{1'b0}};
      out_ready <= 1'b0;
      deg       <= {CNT_W{1'b0}};
      sat       <= 1'b0;
      deg_ovf   <= 1'b0;
    end else begin
      state     <= next_state;
      for (int i = 0; i < 4; i++) acc[i] <= next_acc[i];
      cnt       <= next_cnt;
      node_sat  <= next_node_sat;
      trunc     <= next_trunc;
      out_ready <= do_emit;
      deg_ovf   <= deg_ovf | next_trunc;
      if (do_emit) begin
        x0  <= next_acc[0];
        x1  <= next_acc[1];
        x2  <= next_acc[2];
        x3  <= next_acc[3];
        deg <= next_cnt;
        sat <= next_node_sat;
      end else begin
        x0  <= x0;
        x1  <= x1;
        x2  <= x2;
        x3  <= x3;
        deg <= deg;
        sat <= sat;
      end
    end
  end

endmodule

// File: tb/tb_gnn_aggregator.sv
// Scoreboard bench for gnn_aggregator: directed nodes push expected results,
// a negedge monitor pops and compares on every out_ready pulse.
module tb_gnn_aggregator;

  localparam int DATA_W = 21;
  localparam int CNT_W  = 5;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     feat_valid = 1'b0;
  logic                     feat_last = 1'b0;
  logic signed [DATA_W-1:0] f0 = '0, f1 = '0, f2 = '0, f3 = '0;
  logic                     feat_ready;
  logic signed [DATA_W-1:0] x0, x1, x2, x3;
  logic                     out_ready;
  logic [CNT_W-1:0]         deg;
  logic                     sat;
  logic                     deg_ovf;

  gnn_aggregator #(.DATA_W(DATA_W), .MAX_DEG(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .feat_valid(feat_valid), .feat_last(feat_last),
    .f0(f0), .f1(f1), .f2(f2), .f3(f3), .feat_ready(feat_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3), .out_ready(out_ready),
    .deg(deg), .sat(sat), .deg_ovf(deg_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0; int x1; int x2; int x3; int deg; int sat; int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int a, b, c, d, dg, s, o);
    exp_t e;
    e.x0 = a; e.x1 = b; e.x2 = c; e.x3 = d; e.deg = dg; e.sat = s; e.ovf = o;
    exp_q.push_back(e);
  endtask

  // Present one beat at a negedge, wait (bounded) for feat_ready, return just after the accepting edge.
  task automatic send(input int a, b, c, d, input bit last, output int waits);
    @(negedge clk);
    f0 = DATA_W'(a); f1 = DATA_W'(b); f2 = DATA_W'(c); f3 = DATA_W'(d);
    feat_last = last; feat_valid = 1'b1; waits = 0;
    while (!feat_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: feat_ready stayed 0 for %0d cycles", waits);
    end
    @(posedge clk);
    #1;
    feat_valid = 1'b0; feat_last = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_x0"}, $signed(x0), 0);
    chk({tag, "_x1"}, $signed(x1), 0);
    chk({tag, "_x2"}, $signed(x2), 0);
    chk({tag, "_x3"}, $signed(x3), 0);
    chk({tag, "_out_ready"}, out_ready, 0);
    chk({tag, "_deg"}, deg, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_deg_ovf"}, deg_ovf, 0);
  endtask

  // Monitor: every emit pulse must match the oldest expected node.
  always @(negedge clk) begin
    if (rst_n && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_emit: out_ready=1 with empty scoreboard at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_x0", $signed(x0), e.x0);
        chk("sb_x1", $signed(x1), e.x1);
        chk("sb_x2", $signed(x2), e.x2);
        chk("sb_x3", $signed(x3), e.x3);
        chk("sb_deg", deg, e.deg);
        chk("sb_sat", sat, e.sat);
        chk("sb_deg_ovf", deg_ovf, e.ovf);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_feat_ready", feat_ready, 0);
    check_outputs_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_feat_ready", feat_ready, 1);

    // Single neighbour
    push(5, -3, 0, 1048575, 1, 0, 0);
    send(5, -3, 0, 1048575, 1'b1, w);
    chk("single_out_ready_t1", out_ready, 1);
    chk("single_feat_ready_t1", feat_ready, 0);
    @(posedge clk); #1;
    chk("single_out_ready_t2", out_ready, 0);
    chk("single_feat_ready_t2", feat_ready, 1);

    // Three neighbours with gaps
    push(0, 21, -29, 0, 3, 0, 0);
    send(10, 20, -30, 1, 1'b0, w);
    repeat (2) @(negedge clk);
    send(1, 1, 1, 1, 1'b0, w);
    repeat (3) @(negedge clk);
    chk("three_no_early_emit", out_ready, 0);
    send(-11, 0, 0, -2, 1'b1, w);
    chk("three_pulse_on", out_ready, 1);
    @(posedge clk); #1;
    chk("three_pulse_off", out_ready, 0);
    repeat (3) @(posedge clk); #1;
    chk("three_hold_x1", $signed(x1), 21);
    chk("three_hold_x2", $signed(x2), -29);
    chk("three_hold_deg", deg, 3);

    // Saturation, both directions
    push(1048575, -1048576, 0, 0, 2, 1, 0);
    send(1000000, -1000000, 0, 0, 1'b0, w);
    send(100000, -100000, 0, 0, 1'b1, w);
    @(posedge clk); #1;

    // Degree cap: 18 beats, cut after the 16th, two drained
    push(16, 16, 16, 16, 16, 0, 1);
    for (int i = 1; i <= 18; i++) begin
      send(1, 1, 1, 1, (i == 18), w);
      if (i == 16) chk("cap_emit_after_16", out_ready, 1);
      if (i == 17) chk("cap_beat17_wait", w, 1);
    end
    repeat (2) @(posedge clk); #1;
    chk("cap_ovf_sticky", deg_ovf, 1);
    chk("cap_deg_held", deg, 16);
    push(2, 3, 4, 5, 1, 0, 1);
    send(2, 3, 4, 5, 1'b1, w);
    @(posedge clk); #1;

    // Reset mid-node
    send(9, 9, 9, 9, 1'b0, w);
    send(9, 9, 9, 9, 1'b0, w);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_feat_ready", feat_ready, 0);
    @(posedge clk); #1;
    check_outputs_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst_no_emit", out_ready, 0);
    push(7, 7, 7, 7, 1, 0, 0);
    send(7, 7, 7, 7, 1'b1, w);
    @(posedge clk); #1;

    // Back-to-back nodes: B stalls exactly one cycle behind A's emit
    push(3, -4, 100, -100, 1, 0, 0);
    push(-8, 8, 0, 1, 1, 0, 0);
    send(3, -4, 100, -100, 1'b1, w);
    send(-8, 8, 0, 1, 1'b1, w);
    chk("b2b_b_waits_one", w, 1);
    chk("b2b_b_emit", out_ready, 1);
    @(posedge clk); #1;

    repeat (4) @(posedge clk); #1;
    chk("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
